// File: rtl/uart_cpu_oci_pkg.sv
// Shared definitions for the OCI trace-compaction path (packer and unpacker).
// Holds the default packed-word geometry, the unpacker FSM state type, the
// statistics-counter mode type and the trace symbol codes emitted by the packer.
package uart_cpu_oci_pkg;

  // Default packed-word geometry.
  localparam int unsigned DCT_SYM_W = 2;
  localparam int unsigned DCT_BUF_W = 30;
  localparam int unsigned DCT_CNT_W = 4;
  localparam int unsigned DCT_MAX_N = DCT_BUF_W / DCT_SYM_W;

  // Unpacker FSM states.
  typedef enum logic {
    StIdle = 1'b0,
    StEmit = 1'b1
  } dct_state_e;

  // Statistics counter overflow behaviour.
  typedef enum logic {
    CtrWrap     = 1'b0,
    CtrSaturate = 1'b1
  } stat_ctr_mode_e;

  // Trace symbol codes produced by the packer.
  localparam logic [DCT_SYM_W-1:0] DCT_SYM_NOP    = 2'b00;
  localparam logic [DCT_SYM_W-1:0] DCT_SYM_SEQ    = 2'b01;
  localparam logic [DCT_SYM_W-1:0] DCT_SYM_BRANCH = 2'b10;
  localparam logic [DCT_SYM_W-1:0] DCT_SYM_GAP    = 2'b11;

endpackage

// File: rtl/uart_cpu_oci_dct_stat_ctr.sv
// Statistics event counter with selectable overflow behaviour.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset, clears the count
//   inc_i    - count one event this cycle
//   count_o  - current count; wraps or sticks at all-ones depending on Mode
module uart_cpu_oci_dct_stat_ctr
  import uart_cpu_oci_pkg::*;
#(
  parameter int unsigned    Width = 16,
  parameter stat_ctr_mode_e Mode  = CtrWrap
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if ((Mode == CtrSaturate) && (count_q == '1)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_cpu_oci_dct_unpacker.sv
// Consumer end of the OCI trace-compaction path. Accepts a packed trace word
// (dct_buffer with dct_count valid entries) and serializes it into single trace
// symbols on a valid/ready stream, entry 0 first.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   dct_buffer/dct_count  - packed word and its number of valid entries
//   word_valid/word_ready - word handshake
//   sym_data/sym_last     - current symbol and end-of-word marker
//   sym_valid/sym_ready   - symbol handshake
//   flush                 - abandon the word being emitted
//   busy                  - a word is held
//   sym_total             - symbols delivered (wraps)
//   drop_total            - words dropped: empty, oversized or flushed (saturates)
module uart_cpu_oci_dct_unpacker
  import uart_cpu_oci_pkg::*;
#(
  parameter int unsigned SYM_W  = DCT_SYM_W,
  parameter int unsigned BUF_W  = DCT_BUF_W,
  parameter int unsigned CNT_W  = DCT_CNT_W,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BUF_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_last,
  output logic              sym_valid,
  input  logic              sym_ready,
  input  logic              flush,
  output logic              busy,
  output logic [STAT_W-1:0] sym_total,
  output logic [STAT_W-1:0] drop_total
);

  localparam int unsigned MaxN = BUF_W / SYM_W;

  dct_state_e       state_d, state_q;
  logic [BUF_W-1:0] held_d, held_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] idx_d, idx_q;

  logic             word_xfer;
  logic             sym_xfer;
  logic             count_ok;
  logic             at_last;
  logic             drop;
  logic [SYM_W-1:0] entry_sel;

  assign word_xfer = word_valid & word_ready;
  assign sym_xfer  = sym_valid & sym_ready;
  assign count_ok  = (dct_count != '0) && (32'(dct_count) <= MaxN);
  assign at_last   = (idx_q == (cnt_q - CNT_W'(1)));

  // Symbol mux: select entry idx_q of the held word.
  always_comb begin
    entry_sel = '0;
    for (int unsigned k = 0; k < MaxN; k++) begin
      if (32'(idx_q) == k) begin
        entry_sel = held_q[k*SYM_W +: SYM_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers and symbol index.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (word_xfer) begin
          if (count_ok) begin
            state_d = StEmit;
          end else begin
            drop = 1'b1;
          end
        end
      end
      StEmit: begin
        if (flush) begin
          // A final symbol leaving in the flush cycle completes the word, so
          // nothing is actually abandoned.
          state_d = StIdle;
          drop    = ~(sym_xfer & at_last);
        end else if (sym_xfer && at_last) begin
          // word_ready is only high here, so a chained word lands without a gap.
          if (word_xfer && count_ok) begin
            state_d = StEmit;
          end else begin
            state_d = StIdle;
            drop    = word_xfer;
          end
        end else if (sym_xfer) begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (word_xfer && count_ok) begin
      held_d = dct_buffer;
      cnt_d  = dct_count;
      idx_d  = '0;
    end
  end

  // Outputs.
  always_comb begin
    word_ready = 1'b1;
    sym_valid  = 1'b0;
    sym_last   = 1'b0;
    sym_data   = '0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: word_ready = 1'b1;
      StEmit: begin
        busy       = 1'b1;
        sym_valid  = 1'b1;
        sym_last   = at_last;
        sym_data   = entry_sel;
        word_ready = at_last & sym_ready & ~flush;
      end
      default: word_ready = 1'b1;
    endcase
  end

  uart_cpu_oci_dct_stat_ctr #(
    .Width (STAT_W),
    .Mode  (CtrWrap)
  ) u_sym_ctr (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (sym_xfer),
    .count_o (sym_total)
  );

  uart_cpu_oci_dct_stat_ctr #(
    .Width (STAT_W),
    .Mode  (CtrSaturate)
  ) u_drop_ctr (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (drop),
    .count_o (drop_total)
  );

endmodule

// File: tb/tb_uart_cpu_oci_dct_unpacker.sv
module tb_uart_cpu_oci_dct_unpacker;

  localparam int unsigned SymW  = 2;
  localparam int unsigned BufW  = 30;
  localparam int unsigned CntW  = 4;
  localparam int unsigned StatW = 16;
  localparam int unsigned MaxN  = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [BufW-1:0]  dct_buffer = '0;
  logic [CntW-1:0]  dct_count = '0;
  logic             word_valid = 1'b0;
  logic             word_ready;
  logic [SymW-1:0]  sym_data;
  logic             sym_last;
  logic             sym_valid;
  logic             sym_ready = 1'b0;
  logic             flush = 1'b0;
  logic             busy;
  logic [StatW-1:0] sym_total;
  logic [StatW-1:0] drop_total;

  always #5 clk = ~clk;

  uart_cpu_oci_dct_unpacker dut (
    .clk        (clk),
    .reset      (reset),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .sym_data   (sym_data),
    .sym_last   (sym_last),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .busy       (busy),
    .sym_total  (sym_total),
    .drop_total (drop_total)
  );

  typedef struct packed {
    logic [1:0] data;
    logic       last;
  } sym_t;

  sym_t exp_q[$];   // symbols the DUT still owes, oldest first
  sym_t pend_q[$];  // word accepted this cycle; visible after the edge
  int   checks = 0;
  int   failures = 0;
  int   exp_sym = 0;
  int   exp_drop = 0;
  bit   purge_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge.
  initial begin
    bit         stall_prev = 1'b0;
    logic [1:0] prev_data = '0;
    logic       prev_last = 1'b0;
    sym_t       s;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("sym_valid", 32'(sym_valid), 32'(exp_q.size() > 0));
        check("busy", 32'(busy), 32'(exp_q.size() > 0));
        if (stall_prev && sym_valid) begin
          check("stall_data", 32'(sym_data), 32'(prev_data));
          check("stall_last", 32'(sym_last), 32'(prev_last));
        end
        if (sym_valid && sym_ready) begin
          exp_sym++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_symbol: got %0h with nothing expected", sym_data);
          end else begin
            s = exp_q.pop_front();
            check("sym_data", 32'(sym_data), 32'(s.data));
            check("sym_last", 32'(sym_last), 32'(s.last));
          end
        end
        stall_prev = sym_valid && !sym_ready;
        prev_data  = sym_data;
        prev_last  = sym_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // One clock of stimulus. The expected handshake and drop outcome come from
  // the model queue: empty queue means idle, front entry is the current symbol.
  task automatic cycle(input bit wv, input logic [BufW-1:0] b, input logic [CntW-1:0] c,
                       input bit sr, input bit fl, output bit acc);
    bit   exp_rdy;
    sym_t s;
    logic [BufW-1:0] t;
    @(posedge clk);
    #1;
    if (purge_pending) begin
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        if (s.last) break;
      end
      purge_pending = 1'b0;
    end
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    check("sym_total", 32'(sym_total), 32'(exp_sym % (1 << StatW)));
    check("drop_total", 32'(drop_total), 32'(exp_drop));
    word_valid = wv;
    dct_buffer = b;
    dct_count  = c;
    sym_ready  = sr;
    flush      = fl;
    if (exp_q.size() == 0) exp_rdy = 1'b1;
    else exp_rdy = exp_q[0].last && sr && !fl;
    if (exp_q.size() > 0 && fl && !(sr && exp_q[0].last)) begin
      if (exp_drop < (1 << StatW) - 1) exp_drop++;
      purge_pending = 1'b1;
    end
    acc = wv && exp_rdy;
    if (acc) begin
      if (c == 0 || 32'(c) > MaxN) begin
        if (exp_drop < (1 << StatW) - 1) exp_drop++;
      end else begin
        for (int k = 0; k < int'(c); k++) begin
          t = b >> (2 * k);
          s.data = t[1:0];
          s.last = (k == int'(c) - 1);
          pend_q.push_back(s);
        end
      end
    end
    #2;
    check("word_ready", 32'(word_ready), 32'(exp_rdy));
  endtask

  task automatic idle(input int n, input bit sr);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, sr, 1'b0, acc);
  endtask

  // Offer a word until it is taken, with a cycle bound.
  task automatic send(input logic [BufW-1:0] b, input logic [CntW-1:0] c, input bit sr);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) cycle(1'b1, b, c, sr, 1'b0, acc);
    check("word_accepted", 32'(acc), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    word_valid = 1'b0;
    sym_ready  = 1'b0;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pend_q.delete();
    purge_pending = 1'b0;
    exp_sym  = 0;
    exp_drop = 0;
    check("rst_word_ready", 32'(word_ready), 32'd1);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_sym_last", 32'(sym_last), 32'd0);
    check("rst_sym_data", 32'(sym_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sym_total", 32'(sym_total), 32'd0);
    check("rst_drop_total", 32'(drop_total), 32'd0);
  endtask

  initial begin
    bit              acc;
    logic [BufW-1:0] cur_b;
    logic [CntW-1:0] cur_c;
    bit              have_word;

    do_reset();

    // Single word: symbols 0,1,2,3.
    send(30'h0000_00E4, 4'd4, 1'b1);
    idle(6, 1'b1);

    // Backpressure: symbols 1,2,3 with ready 1,0,0,1,1.
    send(30'h0000_0039, 4'd3, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    idle(3, 1'b1);

    // Chaining: A = {2,1}, B = {3}, offered back to back.
    send(30'h0000_0006, 4'd2, 1'b1);
    send(30'h0000_0003, 4'd1, 1'b1);
    idle(4, 1'b1);

    // Zero-count word, then fifteen 2'b11 symbols.
    send(30'h0000_1234, 4'd0, 1'b1);
    send(30'h3FFF_FFFF, 4'd15, 1'b1);
    idle(18, 1'b1);

    // Flush after five symbols.
    send(30'h1234_5678, 4'd15, 1'b1);
    idle(5, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(3, 1'b1);

    // Flush coinciding with the final symbol: not a drop.
    send(30'h2AAA_5555, 4'd15, 1'b1);
    idle(14, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Flush while idle does not block a word.
    cycle(1'b1, 30'h0000_0009, 4'd2, 1'b1, 1'b1, acc);
    check("idle_flush_accept", 32'(acc), 32'd1);
    idle(4, 1'b1);

    // Reset while emitting index 7.
    send(30'h0ABC_DEF1, 4'd15, 1'b1);
    idle(7, 1'b1);
    do_reset();

    // Randomized traffic.
    have_word = 1'b0;
    cur_b = '0;
    cur_c = '0;
    for (int i = 0; i < 600; i++) begin
      bit wv, sr, fl;
      if (!have_word && $urandom_range(0, 99) < 60) begin
        cur_b = BufW'($urandom);
        cur_c = ($urandom_range(0, 9) == 0) ? 4'd0 : CntW'($urandom_range(1, 15));
        have_word = 1'b1;
      end
      wv = have_word;
      sr = $urandom_range(0, 99) < 70;
      fl = $urandom_range(0, 99) < 5;
      cycle(wv, cur_b, cur_c, sr, fl, acc);
      if (acc) have_word = 1'b0;
    end

    // Drain, bounded.
    for (int i = 0; i < 40 && (exp_q.size() > 0 || pend_q.size() > 0 || purge_pending); i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    end
    idle(2, 1'b1);
    check("drained", 32'(exp_q.size() + pend_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cpu_oci_dct_unpacker.md
Name: uart_cpu_oci_dct_unpacker

Overview:
Consumer end of the OCI trace-compaction path. It accepts a packed trace word (dct_buffer plus dct_count valid entries) and serializes it into individual trace symbols over a valid/ready stream, oldest entry first. It sits between the OCI trace packer and the trace FIFO/host drain logic in the UART Nios subsystem.

Parameters:
SYM_W, 2, width of one trace symbol in bits.
BUF_W, 30, packed word width; max entries MAX_N = BUF_W/SYM_W = 15.
CNT_W, 4, width of the entry count.
STAT_W, 16, width of the statistics counters.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
dct_buffer  in  BUF_W  packed trace word; entry k occupies bits [k*SYM_W +: SYM_W].
dct_count  in  CNT_W  number of valid entries in dct_buffer.
word_valid  in  1  dct_buffer/dct_count are valid.
word_ready  out  1  unpacker accepts a word this cycle.
sym_data  out  SYM_W  current trace symbol.
sym_last  out  1  current symbol is the final entry of its word.
sym_valid  out  1  sym_data valid.
sym_ready  in  1  downstream accepts the symbol.
flush  in  1  discard the word in progress.
busy  out  1  a word is held (state EMIT).
sym_total  out  STAT_W  symbols delivered; wraps.
drop_total  out  STAT_W  words dropped (count 0, count > MAX_N, or flushed); saturates at all-ones.

Behaviour:
- Reset values: word_ready=1, sym_valid=0, sym_last=0, sym_data=0, busy=0, sym_total=0, drop_total=0, state=IDLE, index=0.
- Word transfer: word_valid & word_ready. Symbol transfer: sym_valid & sym_ready.
- States: IDLE, EMIT.
- IDLE: word_ready=1, sym_valid=0.
  - On word transfer with 1 <= dct_count <= MAX_N: latch buffer and count into holding registers, index=0, go to EMIT.
  - dct_count=0: word is consumed, stay in IDLE, drop_total increments.
  - dct_count>MAX_N (unreachable at defaults): word is consumed and dropped the same way.
- EMIT: sym_valid=1, sym_data=held[index*SYM_W +: SYM_W], sym_last=(index==count-1).
  - Symbol transfer with !sym_last: index+1.
  - Symbol transfer with sym_last: word complete.
  - Latency: first symbol is valid the cycle after the word transfer (1 cycle).
  - sym_data and sym_last are stable while sym_valid & !sym_ready.
- Zero-bubble chaining: in EMIT, word_ready = sym_last & sym_ready & !flush.
  - A word accepted in the same cycle as the final symbol transfer is loaded directly; state stays EMIT with index=0. No idle cycle between words.
  - If that chained word has count 0, it is dropped and the state goes to IDLE.
- Final symbol transfer with no chained word: go to IDLE.
- sym_total increments by 1 per symbol transfer and wraps modulo 2^STAT_W.
- flush, in EMIT: the held word is abandoned and drop_total increments.
  - Next cycle: IDLE, sym_valid=0.
  - Any symbol transfer in the flush cycle still counts in sym_total.
  - word_ready=0 in the flush cycle.
- flush, in IDLE: no effect; word_ready stays 1 and words are accepted normally.
- Simultaneous flush and final symbol transfer: the symbol counts and the word is NOT counted as dropped; the next state is IDLE.
- drop_total saturates at 2^STAT_W-1.
- reset mid-EMIT: held word discarded, outputs return to reset values next cycle, counters cleared.
- busy = (state==EMIT).

Decomposition:
- Shared package uart_cpu_oci_pkg holds:
  - state enum {IDLE, EMIT}
  - localparams DCT_SYM_W=2, DCT_BUF_W=30, DCT_CNT_W=4, DCT_MAX_N=15
  - symbol code constants used by the packer
- One sub-module is natural: uart_cpu_oci_dct_stat_ctr, a counter with a wrap/saturate mode select, instantiated twice.
- Symbol mux and index logic stay in the top module.

Test Plan:
- Single word: dct_buffer=30'h0000_00E4, count=4, sym_ready=1.
  - Required: symbols 0,1,2,3 on 4 consecutive cycles starting 1 cycle after transfer.
  - sym_last only on the 4th symbol; sym_total=4; back to IDLE.
- Backpressure: count=3, buffer=30'h0000_0039.
  - Toggle sym_ready 1,0,0,1,1.
  - Required: symbols 1,2,3 delivered in order; sym_data stable while stalled; exactly 3 transfers.
- Chaining: word A (count=2, 30'h0000_0006) then word B (count=1, 30'h0000_0003), both held valid.
  - Required: output 2,1,3 on 3 consecutive cycles.
  - word_ready high exactly in the cycle of A's last symbol.
- Zero count: a word with count=0.
  - Required: consumed in 1 cycle, no sym_valid, drop_total=1.
  - A following word with count=15, all symbols 2'b11, yields 15 symbols, sym_last on the 15th.
- Flush: count=15; assert flush after 5 symbols.
  - Required: sym_valid=0 next cycle, sym_total=5, drop_total=1.
  - Repeat with flush on the last-symbol cycle: drop_total unchanged.
- Reset mid-word: assert reset during EMIT at index 7.
  - Required: next cycle sym_valid=0, word_ready=1, busy=0, sym_total=0, drop_total=0.
